// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug read-out path.
package mips_dbg_pkg;

   localparam int REG_AW    = 5;
   localparam int REG_DW    = 32;
   localparam int REG_COUNT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// Register-file dump engine: borrows one read port, walks FIRST_REG..LAST_REG
// and streams {index, value} words out on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; read port address held
// READ  | RN = idx, register value captured at end of cycle
// SEND  | word presented; waits for out_ready
// DONE  | one-cycle done pulse, then IDLE
module reg_dump
   import mips_dbg_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [REG_AW-1:0] RN,
   input  logic [REG_DW-1:0] RD,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_idx,
   output logic [REG_DW-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
   localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

   dump_state_e       state_q, state_d;
   logic [REG_AW-1:0] idx_q, idx_d;
   logic [REG_AW-1:0] rn_q, rn_d;
   logic              out_valid_q, out_valid_d;
   logic [REG_AW-1:0] out_idx_q, out_idx_d;
   logic [REG_DW-1:0] out_data_q, out_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next-state and output decode; RN is loaded on entry to READ so that the
   // registered address is already valid during the READ cycle itself.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rn_d        = rn_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;

      if (abort) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_READ;
                  idx_d   = FIRST_IDX;
                  rn_d    = FIRST_IDX;
               end
            end
            ST_READ: begin
               out_data_d  = RD;
               out_idx_d   = idx_q;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
            ST_SEND: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  // Terminate on compare so LAST_REG = 31 never wraps to 0.
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx_q + 5'd1;
                     rn_d    = idx_q + 5'd1;
                     state_d = ST_READ;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rn_q        <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rn_q        <= rn_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign RN        = rn_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump with a behavioural register file.
module tb_reg_dump;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  WN;
   logic [31:0] WD;
   logic [31:0] rf [32];
   logic [31:0] mdl [32];

   logic        start_a, abort_a, ready_a, valid_a, busy_a, done_a;
   logic [4:0]  RN_a, idx_a;
   logic [31:0] RD_a, data_a;
   logic        start_b, abort_b, ready_b, valid_b, busy_b, done_b;
   logic [4:0]  RN_b, idx_b;
   logic [31:0] RD_b, data_b;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   typedef struct {
      logic        rdy;
      logic        vld;
      logic [4:0]  idx;
      logic [31:0] data;
   } step_t;
   step_t pat [8];

   always #5 clk = ~clk;

   // Register file: write on rising edge, combinational reads, r0 reads 0.
   always @(posedge clk) if (RegWrite && WN != 5'd0) rf[WN] <= WD;
   assign RD_a = (RN_a == 5'd0) ? 32'd0 : rf[RN_a];
   assign RD_b = (RN_b == 5'd0) ? 32'd0 : rf[RN_b];

   always @(posedge clk) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   reg_dump dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .RN(RN_a), .RD(RD_a), .out_valid(valid_a), .out_ready(ready_a),
      .out_idx(idx_a), .out_data(data_a), .busy(busy_a), .done(done_a)
   );

   reg_dump #(.FIRST_REG(5), .LAST_REG(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .RN(RN_b), .RD(RD_b), .out_valid(valid_b), .out_ready(ready_b),
      .out_idx(idx_b), .out_data(data_b), .busy(busy_b), .done(done_b)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stream dut_a words with ready high until the word stop_idx is presented,
   // pulsing start while word start_at is on the bus.
   task automatic stream_until(input int first_idx, input int stop_idx, input int start_at);
      int exp_i = first_idx;
      int c = 0;
      ready_a = 1'b1;
      while (!(valid_a && idx_a == 5'(stop_idx)) && c < 200) begin
         start_a = valid_a && (idx_a == 5'(start_at)) && (start_at >= 0);
         if (valid_a) begin
            check("stream_idx", 32'(idx_a), 32'(exp_i));
            check("stream_data", data_a, mdl[exp_i]);
            exp_i++;
         end
         tick();
         c++;
      end
      start_a = 1'b0;
      check("stream_reach_valid", 32'(valid_a), 32'd1);
      check("stream_reach_idx", 32'(idx_a), 32'(stop_idx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, c, first_valid, last_hs;

      pat[0] = '{1'b1, 1'b0, 5'd0, 32'd0};
      pat[1] = '{1'b0, 1'b1, 5'd0, 32'd0};
      pat[2] = '{1'b0, 1'b1, 5'd0, 32'd0};
      pat[3] = '{1'b1, 1'b1, 5'd0, 32'd0};
      pat[4] = '{1'b1, 1'b0, 5'd0, 32'd0};
      pat[5] = '{1'b0, 1'b1, 5'd1, 32'd101};
      pat[6] = '{1'b0, 1'b1, 5'd1, 32'd101};
      pat[7] = '{1'b1, 1'b1, 5'd1, 32'd101};

      rst_n = 1'b0; RegWrite = 1'b0; WN = '0; WD = '0;
      start_a = 0; abort_a = 0; ready_a = 0;
      start_b = 0; abort_b = 0; ready_b = 0;
      mdl[0] = 32'd0;
      tick();
      for (int i = 1; i < 32; i++) begin
         RegWrite = 1'b1; WN = 5'(i); WD = 32'(100 + i); mdl[i] = 32'(100 + i);
         tick();
      end
      RegWrite = 1'b0;

      // Reset values
      check("rst_RN", 32'(RN_a), 0);
      check("rst_valid", 32'(valid_a), 0);
      check("rst_idx", 32'(idx_a), 0);
      check("rst_data", data_a, 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_b_RN", 32'(RN_b), 0);
      rst_n = 1'b1;
      tick();

      // Full 32-register dump, ready held high
      ready_a = 1'b1; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("full_busy_rise", 32'(busy_a), 1);
      check("full_valid_read", 32'(valid_a), 0);
      check("full_RN0", 32'(RN_a), 0);
      got = 0; c = 0; first_valid = -1; last_hs = -1;
      while (got < 32 && c < 200) begin
         if (valid_a) begin
            if (first_valid < 0) first_valid = c;
            check("full_idx", 32'(idx_a), 32'(got));
            check("full_data", data_a, mdl[got]);
            last_hs = c + 1;
            got++;
         end
         tick();
         c++;
      end
      check("full_words", 32'(got), 32);
      check("full_first_valid", 32'(first_valid), 1);
      check("full_last_hs", 32'(last_hs), 64);
      check("full_done", 32'(done_a), 1);
      check("full_busy_done", 32'(busy_a), 1);
      tick();
      check("full_done_fall", 32'(done_a), 0);
      check("full_busy_fall", 32'(busy_a), 0);
      check("full_done_cnt", 32'(done_cnt_a), 1);

      // Sub-range dump 5..7 on the second instance
      ready_b = 1'b1; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      got = 0; c = 0;
      while (got < 3 && c < 50) begin
         if (valid_b) begin
            check("sub_idx", 32'(idx_b), 32'(5 + got));
            check("sub_data", data_b, mdl[5 + got]);
            got++;
         end
         tick();
         c++;
      end
      check("sub_words", 32'(got), 3);
      check("sub_done", 32'(done_b), 1);
      tick();
      check("sub_done_fall", 32'(done_b), 0);
      check("sub_busy_fall", 32'(busy_b), 0);
      check("sub_done_cnt", 32'(done_cnt_b), 1);

      // Back-pressure pattern 1,0,0,1 from the table
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int s = 0; s < 8; s++) begin
         ready_a = pat[s].rdy;
         check("bp_valid", 32'(valid_a), 32'(pat[s].vld));
         if (pat[s].vld) begin
            check("bp_idx", 32'(idx_a), 32'(pat[s].idx));
            check("bp_data", data_a, pat[s].data);
         end
         tick();
      end

      // Coherency on word 3
      ready_a = 1'b1;
      check("coh_read2_valid", 32'(valid_a), 0);
      check("coh_RN2", 32'(RN_a), 2);
      tick();
      check("coh_word2", data_a, 32'd102);
      RegWrite = 1'b1; WN = 5'd3; WD = 32'hDEAD;
      tick();
      RegWrite = 1'b0;
      check("coh_RN3", 32'(RN_a), 3);
      tick();
      check("coh_idx3", 32'(idx_a), 3);
      check("coh_dead", data_a, 32'hDEAD);
      ready_a = 1'b0;
      RegWrite = 1'b1; WN = 5'd3; WD = 32'hBEEF; mdl[3] = 32'hBEEF;
      tick();
      RegWrite = 1'b0;
      check("coh_hold_valid", 32'(valid_a), 1);
      check("coh_hold_dead", data_a, 32'hDEAD);
      ready_a = 1'b1;
      tick();

      // Start during dump is ignored; abort at word 10
      stream_until(4, 10, 5);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("abort_valid", 32'(valid_a), 0);
      check("abort_busy", 32'(busy_a), 0);
      check("abort_done", 32'(done_a), 0);
      check("abort_RN_hold", 32'(RN_a), 10);
      tick();
      tick();
      check("abort_no_done", 32'(done_cnt_a), 1);
      check("abort_idle_valid", 32'(valid_a), 0);

      // Restart from 0, then reset mid-dump at word 20
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("restart_busy", 32'(busy_a), 1);
      check("restart_RN0", 32'(RN_a), 0);
      stream_until(0, 20, -1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_RN", 32'(RN_a), 0);
      check("mrst_valid", 32'(valid_a), 0);
      check("mrst_idx", 32'(idx_a), 0);
      check("mrst_data", data_a, 0);
      check("mrst_busy", 32'(busy_a), 0);
      check("mrst_done", 32'(done_a), 0);
      tick();
      check("mrst_idle_busy", 32'(busy_a), 0);

      // Start together with abort in IDLE: abort wins
      start_a = 1'b1; abort_a = 1'b1;
      tick();
      start_a = 1'b0; abort_a = 1'b0;
      check("sa_busy", 32'(busy_a), 0);
      tick();
      check("sa_valid", 32'(valid_a), 0);
      check("sa_busy2", 32'(busy_a), 0);
      check("final_done_cnt", 32'(done_cnt_a), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
